nbin_decoder_scan: RTL

//  Parametrised, registered SEL_W-to-2**SEL_W one-hot decoder driving the LED bank.

---
 rtl/nbin_decoder_scan_pkg.sv | 15 +
 rtl/nbin_decoder_scan_if.sv | 17 +
 rtl/nbin_decoder_scan_tick_prescaler.sv | 24 ++
 rtl/nbin_decoder_scan.sv | 111 +++++++++++
 4 files changed

// File: rtl/nbin_decoder_scan_pkg.sv
// Shared definitions for the LED-bank decoder: operating modes and helpers.
package nbin_decoder_scan_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  function automatic logic is_scan(input logic [1:0] m);
    return (m == MODE_SCAN_UP) || (m == MODE_SCAN_DOWN);
  endfunction

endpackage

// File: rtl/nbin_decoder_scan_if.sv
// Control/status bundle between switch logic (master) and the decoder (slave).
interface nbin_decoder_scan_if #(
  parameter int SEL_W = 4
);
  localparam int OUT_W = 1 << SEL_W;

  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [SEL_W-1:0] a;
  logic [OUT_W-1:0] led;
  logic [SEL_W-1:0] pos;
  logic             wrap;

  modport master (output en, mode, load, a, input led, pos, wrap);
  modport slave  (input en, mode, load, a, output led, pos, wrap);
endinterface

// File: rtl/nbin_decoder_scan_tick_prescaler.sv
// Divides enabled clock cycles by DIV; tick is high on the last count of each period.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = en & (cnt_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end
endmodule

// File: rtl/nbin_decoder_scan.sv
// Registered one-hot LED decoder with direct, scan up/down, load and hold modes.
// Build option DECODER_BOUNCE_EN: scans reverse at the end points instead of wrapping.
module nbin_decoder_scan
  import nbin_decoder_scan_pkg::*;
#(
  parameter int SEL_W    = 4,
  parameter int TICK_DIV = 4
) (
  input logic                 clk,
  input logic                 rst,
  nbin_decoder_scan_if.slave  bus
);
  localparam int OUT_W = 1 << SEL_W;
  localparam logic [SEL_W-1:0] POS_MAX = SEL_W'(OUT_W - 1);

  logic             tick;
  logic [SEL_W-1:0] pos_reg, pos_next;
  logic [OUT_W-1:0] led_reg, led_next;
  logic             wrap_reg, wrap_next;
  logic             dir_up_reg, dir_up_next;
  logic             dir_up_eff;
  logic             dir_load;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .tick (tick)
  );

`ifdef DECODER_BOUNCE_EN
  // Direction only follows mode on entry, so a reversal survives the rest of the scan.
  logic [1:0] mode_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_prev_reg <= MODE_DIRECT;
    end else begin
      mode_prev_reg <= bus.mode;
    end
  end

  assign dir_load = is_scan(bus.mode) && (bus.mode != mode_prev_reg);
`else
  assign dir_load = is_scan(bus.mode);
`endif

  assign dir_up_eff = dir_load ? (bus.mode == MODE_SCAN_UP) : dir_up_reg;

  always_comb begin
    pos_next    = pos_reg;
    wrap_next   = 1'b0;
    dir_up_next = dir_up_eff;
    if (bus.en) begin
      if (bus.mode == MODE_DIRECT) begin
        pos_next = bus.a;
      end else if (bus.load) begin
        pos_next = bus.a;
      end else if ((bus.mode != MODE_HOLD) && tick) begin
        if (dir_up_eff) begin
          if (pos_reg == POS_MAX) begin
            wrap_next = 1'b1;
`ifdef DECODER_BOUNCE_EN
            pos_next    = pos_reg - 1'b1;
            dir_up_next = 1'b0;
`else
            pos_next    = '0;
`endif
          end else begin
            pos_next = pos_reg + 1'b1;
          end
        end else begin
          if (pos_reg == '0) begin
            wrap_next = 1'b1;
`ifdef DECODER_BOUNCE_EN
            pos_next    = pos_reg + 1'b1;
            dir_up_next = 1'b1;
`else
            pos_next    = POS_MAX;
`endif
          end else begin
            pos_next = pos_reg - 1'b1;
          end
        end
      end
    end
  end

  // Decode the next position so led and pos update on the same edge.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
    assign led_next[gi] = bus.en & (pos_next == SEL_W'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_reg    <= '0;
      led_reg    <= '0;
      wrap_reg   <= 1'b0;
      dir_up_reg <= 1'b1;
    end else begin
      pos_reg    <= pos_next;
      led_reg    <= led_next;
      wrap_reg   <= wrap_next;
      dir_up_reg <= dir_up_next;
    end
  end

  assign bus.pos  = pos_reg;
  assign bus.led  = led_reg;
  assign bus.wrap = wrap_reg;
endmodule
